// File: rtl/mac_mul_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_mul_unit : radix-2 shift-add multiply / multiply-accumulate unit.    |
// | Optional: MAC_EARLY_TERM_EN ends CALC once the remaining multiplier is 0.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_mul_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'd8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic             mac_select,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             mac_q,     mac_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] result_q,  result_d;

  logic             w_launch;
  logic             w_calc_last;
  logic [WIDTH-1:0] w_partial_sum;
  logic [WIDTH-1:0] w_acc_sum;

  assign w_launch      = (state_q == S_IDLE) && start && (alu_control == MUL_CODE);
  assign w_partial_sum = partial_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  assign w_acc_sum     = acc_q + w_partial_sum;

`ifdef MAC_EARLY_TERM_EN
  // Remaining multiplier after this cycle's shift is zero: nothing left to add.
  assign w_calc_last = (count_q == C_LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign w_calc_last = (count_q == C_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    count_d   = count_q;
    mac_d     = mac_q;
    acc_d     = acc_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        // Clear takes effect before a same-edge launch, so a MAC adds to zero.
        if (acc_clr) begin
          acc_d = '0;
        end
        if (w_launch) begin
          mcand_d   = op_a;
          mplier_d  = op_b;
          mac_d     = mac_select;
          partial_d = '0;
          count_d   = '0;
          state_d   = S_CALC;
        end
      end

      S_CALC: begin
        partial_d = w_partial_sum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        count_d   = count_q + CW'(1);
        if (w_calc_last) begin
          state_d = S_DONE;
          if (mac_q) begin
            acc_d    = w_acc_sum;
            result_d = w_acc_sum;
          end else begin
            result_d = w_partial_sum;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      count_q   <= '0;
      mac_q     <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      count_q   <= count_d;
      mac_q     <= mac_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign acc_out = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_mul_unit.sv
`default_nettype none
// Testbench for mac_mul_unit: random operations against a cycle-stamped
// behavioural model, plus literal checks of the documented examples.
module tb_mac_mul_unit;

  localparam int         W   = 32;
  localparam logic [3:0] MUL = 4'd8;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_control = 4'd0;
  logic         mac_select = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         acc_clr = 1'b0;
  logic         busy, done;
  logic [W-1:0] result, acc_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_mul_unit #(.WIDTH(W), .MUL_CODE(MUL)) dut (
    .clk(clk), .arst(arst), .start(start), .alu_control(alu_control),
    .mac_select(mac_select), .op_a(op_a), .op_b(op_b), .acc_clr(acc_clr),
    .busy(busy), .done(done), .result(result), .acc_out(acc_out)
  );

  // Number of CALC cycles an operation needs.
  function automatic int exp_calc_cycles(input logic [W-1:0] b);
`ifdef MAC_EARLY_TERM_EN
    for (int i = 1; i < W; i++) begin
      if ((b >> i) == '0) return i;
    end
    return W;
`else
    return W;
`endif
  endfunction

  // Model: an operation launched at edge k commits its result at edge k+L
  // (done visible after it) and the unit ignores inputs at edge k+L+1.
  bit           m_active    = 1'b0;
  bit           m_mac       = 1'b0;
  logic [W-1:0] m_prod      = '0;
  logic [W-1:0] m_acc       = '0;
  logic [W-1:0] m_res       = '0;
  int           m_edge      = 0;
  int           m_done_edge = 0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_active <= 1'b0;
      m_acc    <= '0;
      m_res    <= '0;
      m_edge   <= 0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_active && m_edge == m_done_edge) begin
        if (m_mac) begin
          m_acc <= m_acc + m_prod;
          m_res <= m_acc + m_prod;
        end else begin
          m_res <= m_prod;
        end
      end else if (m_active && m_edge == m_done_edge + 1) begin
        m_active <= 1'b0;
      end else if (!m_active) begin
        if (acc_clr) m_acc <= '0;
        if (start && alu_control == MUL) begin
          m_active    <= 1'b1;
          m_mac       <= mac_select;
          m_prod      <= op_a * op_b;
          m_done_edge <= m_edge + exp_calc_cycles(op_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic eb, ed;
    forever begin
      @(negedge clk);
      eb = m_active && ((m_edge - 1) < m_done_edge);
      ed = m_active && ((m_edge - 1) == m_done_edge);
      check("cyc_busy",    {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, eb});
      check("cyc_done",    {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, ed});
      check("cyc_result",  result,  m_res);
      check("cyc_acc_out", acc_out, m_acc);
    end
  endtask

  // Launch one operation and wait for done; lat follows the k+N numbering.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic mac,
                        input logic clr, input logic noise,
                        output logic [W-1:0] res, output int lat);
    int n;
    @(posedge clk); #1;
    start = 1'b1; alu_control = MUL; op_a = a; op_b = b; mac_select = mac; acc_clr = clr;
    @(posedge clk); #1;
    start = 1'b0; acc_clr = 1'b0;
    op_a = $urandom; op_b = $urandom; mac_select = 1'($urandom); alu_control = 4'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && noise) begin
        start = 1'($urandom); acc_clr = 1'($urandom);
      end
    end
    start = 1'b0; acc_clr = 1'b0;
    if (done !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout: no done within %0d cycles", n);
      lat = -1;
    end else begin
      lat = n + 1;
    end
    res = result;
  endtask

  logic [W-1:0] r;
  int           lat;

  initial begin
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    check("reset_result", result, '0);
    check("reset_acc",    acc_out, '0);
    check("reset_busy",   {{(W-1){1'b0}}, busy}, '0);
    fork compare_loop(); join_none

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, r, lat);
    check("mul_7x6", r, 32'd42);
    check("mul_7x6_acc", acc_out, 32'd0);
`ifdef MAC_EARLY_TERM_EN
    check("mul_7x6_lat", lat, 32'd4);
`else
    check("mul_7x6_lat", lat, 32'd33);
`endif

    run_op(32'd3, 32'd4, 1'b1, 1'b1, 1'b0, r, lat);
    check("mac_3x4", r, 32'd12);
    run_op(32'd5, 32'd5, 1'b1, 1'b0, 1'b0, r, lat);
    check("mac_5x5", r, 32'd37);
    check("mac_5x5_acc", acc_out, 32'd37);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, r, lat);
    check("mul_wrap", r, 32'd1);
    check("mul_keeps_acc", acc_out, 32'd37);

    run_op(32'hFFFF_FFF0, 32'd1, 1'b1, 1'b1, 1'b0, r, lat);
    check("acc_preload", acc_out, 32'hFFFF_FFF0);
    run_op(32'd4, 32'd4, 1'b1, 1'b0, 1'b0, r, lat);
    check("acc_wrap", acc_out, 32'd0);

    @(posedge clk); #1;
    start = 1'b1; alu_control = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignore_other_op", {{(W-1){1'b0}}, busy}, '0);

    run_op(32'd9, 32'd9, 1'b1, 1'b0, 1'b1, r, lat);
    check("mac_with_noise", r, 32'd81);
    check("mac_with_noise_acc", acc_out, 32'd81);

    @(posedge clk); #1;
    start = 1'b1; alu_control = MUL; op_a = 32'd100; op_b = 32'd100; mac_select = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 arst = 1'b1;
    #1;
    check("arst_busy",   {{(W-1){1'b0}}, busy}, '0);
    check("arst_done",   {{(W-1){1'b0}}, done}, '0);
    check("arst_acc",    acc_out, '0);
    check("arst_result", result, '0);
    @(posedge clk); #1 arst = 1'b0;
    run_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, r, lat);
    check("post_reset_mul", r, 32'd6);

    run_op(32'd5, 32'd1, 1'b0, 1'b0, 1'b0, r, lat);
    check("mul_5x1", r, 32'd5);
    run_op(32'd3, 32'h8000_0000, 1'b0, 1'b0, 1'b0, r, lat);
    check("mul_3xmsb", r, 32'h8000_0000);
    check("mul_3xmsb_lat", lat, 32'd33);
`ifdef MAC_EARLY_TERM_EN
    run_op(32'd5, 32'd1, 1'b0, 1'b0, 1'b0, r, lat);
    check("early_5x1_lat", lat, 32'd2);
    run_op(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, r, lat);
    check("early_5x0_lat", lat, 32'd2);
    check("early_5x0", r, 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        start = 1'($urandom); alu_control = 4'($urandom_range(0, 7));
        acc_clr = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        start = 1'b0; acc_clr = 1'b0;
      end else begin
        run_op($urandom, $urandom >> $urandom_range(0, 31), 1'($urandom),
               ($urandom_range(0, 3) == 0), 1'b1, r, lat);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
